lcd_bus_master: RTL
===================

LCD_BUS_MASTER -- requirements
Module: lcd_bus_master

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 20: clocks nCS plus strobe held low per bus cycle (≥17 covers the downstream EN sequence).
REQ-002 SHALL have parameter GAP_CYCLES, default 4: clocks with all strobes high between bus cycles.
REQ-003 SHALL have parameter POLL_LIMIT, default 1000: maximum busy-flag reads per request.
REQ-004 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  reset, asynchronous, active-high
  req_valid  in  1  request present
  req_ready  out  1  block can accept request
  req_rs  in  1  register select: 0 command, 1 data
  req_data  in  8  byte to write
  nCS  out  1  chip select to LCD controller, active-low
  nWR  out  1  write strobe, active-low
  nRD  out  1  read strobe, active-low
  RS  out  1  register select to LCD controller
  db_out  out  8  LCD data bus drive value
  db_oe  out  1  data bus output enable
  db_in  in  8  LCD data bus sampled value
  busy  out  1  transaction in progress
  timeout  out  1  sticky: last request hit POLL_LIMIT
  lcd_addr  out  7  address counter from last poll (db_in[6:0])

Function
REQ-005 SHALL implement states IDLE, WR, GAP_W, POLL, GAP_P; all outputs registered.
REQ-006 IDLE: req_ready=1, busy=0; on req_valid=1, SHALL latch req_rs/req_data, clear timeout, zero poll counter, enter WR.
REQ-007 Request SHALL be accepted only on an edge where req_valid and req_ready are both 1; req_ready SHALL be 0 in every other state.
REQ-008 WR SHALL begin the cycle after acceptance: nCS=0, nWR=0, nRD=1, RS=latched rs, db_out=latched data, db_oe=1, held exactly STROBE_CYCLES clocks, then GAP_W.
REQ-009 GAP_W and GAP_P: nCS=nWR=nRD=1, db_oe=0, RS and db_out unchanged, exactly GAP_CYCLES clocks.
REQ-010 GAP_W SHALL exit to POLL.
REQ-011 POLL: nCS=0, nRD=0, nWR=1, RS=0, db_oe=0, exactly STROBE_CYCLES clocks; db_in SHALL be sampled on the last POLL clock into busy_flag (bit 7) and lcd_addr (bits 6:0).
REQ-012 GAP_P exit: busy_flag=0 -> IDLE; busy_flag=1 with poll count = POLL_LIMIT-1 -> timeout=1, IDLE; otherwise increment poll count, re-enter POLL.
REQ-013 nWR and nRD SHALL never be low simultaneously; a strobe SHALL never be low while nCS is high.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Single request, not busy on first poll: total occupancy = 2*STROBE_CYCLES + 2*GAP_CYCLES clocks (48 at defaults).
REQ-016 req_valid changes while not in IDLE SHALL be ignored; latched data SHALL NOT change mid-transaction.
REQ-017 Cycle counter SHALL reload on every state entry; poll counter width SHALL be clog2(POLL_LIMIT), no wrap.

Reset
REQ-018 rst=1 SHALL immediately force IDLE, nCS=nWR=nRD=1, RS=0, db_out=0, db_oe=0, busy=0, timeout=0, lcd_addr=0, counters=0.
REQ-019 Reset during any state SHALL abort the bus cycle with no further strobe activity; the first post-reset request SHALL behave as REQ-015.

Structure
REQ-020 State encoding and default timing constants SHALL live in shared package lcd_pkg.
REQ-021 The per-state duration counter SHALL be sub-module lcd_cycle_timer (load value, start, done pulse).

Verification
REQ-022 Write 0x38, RS=0, db_in=0x05: nCS/nWR low 20 clocks with db_out=0x38, 4-clock gap, nCS/nRD low 20 clocks, 4-clock gap, IDLE; lcd_addr=0x05, timeout=0.
REQ-023 Data write 0x41, RS=1, db_in=0x80 for 3 polls then 0x00: RS=1 during WR, RS=0 during POLLs, exactly 4 POLL cycles, then req_ready=1.
REQ-024 POLL_LIMIT=8, db_in fixed 0x80: exactly 8 POLL cycles, timeout=1; next request clears timeout on acceptance.
REQ-025 req_valid held high for 2 back-to-back requests: second accepted only after IDLE return, never during WR/POLL.
REQ-026 rst asserted mid-WR (clock 10): same-cycle strobes high, db_oe=0; next request completes per REQ-015.
REQ-027 Assertion on every clock: never (nWR=0 and nRD=0), never (nCS=1 and strobe low), db_oe=1 only in WR.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus master: state encoding and default timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    GAP_W = 3'd2,
    POLL  = 3'd3,
    GAP_P = 3'd4
  } lcdState_t;

  localparam int DEF_STROBE_CYCLES = 20;
  localparam int DEF_GAP_CYCLES    = 4;
  localparam int DEF_POLL_LIMIT    = 1000;

  // Width of the per-state duration counter.
  localparam int TIMER_W = 16;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Per-state duration counter. A start pulse loads a cycle count; done is
// high during the last cycle of the loaded duration, so a state that starts
// the timer on entry and leaves on done lasts exactly loadValue clocks.
module lcd_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] loadValue,
  output logic         done
);

  logic [W-1:0] count;
  logic         active;

  // Load on start, otherwise count down while active and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      count  <= loadValue - 1'b1;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) begin
        active <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = active && (count == '0);

endmodule

// File: rtl/lcd_bus_master.sv
// LCD controller bus master: writes one byte (command or data) with an
// nCS/nWR strobe, then polls the busy flag with nCS/nRD read cycles until the
// controller reports ready or the poll limit is reached.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE, and the request fields
// are captured on that same edge and held until the transaction ends.
module lcd_bus_master
  import lcd_pkg::*;
#(
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int POLL_LIMIT    = DEF_POLL_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       nWR,
  output logic       nRD,
  output logic       RS,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [7:0] db_in,
  output logic       busy,
  output logic       timeout,
  output logic [6:0] lcd_addr
);

  localparam int PCW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  lcdState_t          state;
  lcdState_t          nextState;
  logic               timerStart;
  logic [TIMER_W-1:0] timerLoad;
  logic               timerDone;
  logic [PCW-1:0]     pollCnt;
  logic               busyFlag;
  logic               accept;
  logic               pollLast;

  assign accept   = req_valid && req_ready;
  assign pollLast = (pollCnt == PCW'(POLL_LIMIT - 1));

  lcd_cycle_timer #(.W(TIMER_W)) uTimer (
    .clk       (clk),
    .rst       (rst),
    .start     (timerStart),
    .loadValue (timerLoad),
    .done      (timerDone)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic; the timer is reloaded on every state entry.
  always_comb begin
    nextState  = state;
    timerStart = 1'b0;
    timerLoad  = '0;
    case (state)
      IDLE: if (accept) begin
        nextState  = WR;
        timerStart = 1'b1;
        timerLoad  = TIMER_W'(STROBE_CYCLES);
      end
      WR: if (timerDone) begin
        nextState  = GAP_W;
        timerStart = 1'b1;
        timerLoad  = TIMER_W'(GAP_CYCLES);
      end
      GAP_W: if (timerDone) begin
        nextState  = POLL;
        timerStart = 1'b1;
        timerLoad  = TIMER_W'(STROBE_CYCLES);
      end
      POLL: if (timerDone) begin
        nextState  = GAP_P;
        timerStart = 1'b1;
        timerLoad  = TIMER_W'(GAP_CYCLES);
      end
      GAP_P: if (timerDone) begin
        if (!busyFlag || pollLast) begin
          nextState = IDLE;
        end else begin
          nextState  = POLL;
          timerStart = 1'b1;
          timerLoad  = TIMER_W'(STROBE_CYCLES);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Registered bus outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nCS       <= 1'b1;
      nWR       <= 1'b1;
      nRD       <= 1'b1;
      RS        <= 1'b0;
      db_out    <= 8'h00;
      db_oe     <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      nCS       <= !((nextState == WR) || (nextState == POLL));
      nWR       <= (nextState != WR);
      nRD       <= (nextState != POLL);
      db_oe     <= (nextState == WR);
      busy      <= (nextState != IDLE);
      req_ready <= (nextState == IDLE);
      if (accept) begin
        RS     <= req_rs;
        db_out <= req_data;
      end else if (nextState == POLL) begin
        RS <= 1'b0;
      end
    end
  end

  // Poll bookkeeping: sample status on the last read clock, count polls,
  // flag a timeout when the limit is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyFlag <= 1'b0;
      lcd_addr <= 7'h00;
      pollCnt  <= '0;
      timeout  <= 1'b0;
    end else begin
      if (accept) begin
        timeout <= 1'b0;
        pollCnt <= '0;
      end
      if ((state == POLL) && timerDone) begin
        busyFlag <= db_in[7];
        lcd_addr <= db_in[6:0];
      end
      if ((state == GAP_P) && timerDone && busyFlag) begin
        if (pollLast) timeout <= 1'b1;
        else          pollCnt <= pollCnt + 1'b1;
      end
    end
  end

endmodule
